instr_fetch_unit: RTL and testbench

- Front end of the 24-bit CPU.
- Holds the PC, issues word reads to instruction memory over a req/ready + rvalid handshake, and registers each returned 24-bit word.
- Presents the word, its PC and its 4-bit OPCODE field to the decode stage; OPCODE drives the control unit directly.
- Handles decode-stage stall (2-entry output/skid buffer) and branch redirect, including flushing an in-flight fetch.

---
 rtl/cpu24_pkg.sv | 21 ++
 rtl/instr_fetch_unit_if.sv | 30 +++
 rtl/instr_fetch_unit_skid.sv | 102 ++++++++++
 rtl/instr_fetch_unit_sva.sv | 20 ++
 rtl/instr_fetch_unit.sv | 126 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 263 ++++++++++++++++++++++++++
 6 files changed

// File: rtl/cpu24_pkg.sv
// Shared definitions for the 24-bit CPU: instruction geometry, opcodes,
// and the instruction-fetch FSM state type.
package cpu24_pkg;

  localparam int INSTR_W = 24;
  localparam int OPC_W   = 4;
  localparam int OPC_MSB = INSTR_W - 1;

  localparam logic [3:0] OP_RTYPE = 4'b0110;
  localparam logic [3:0] OP_ADDI  = 4'b0001;
  localparam logic [3:0] OP_LW    = 4'b0010;
  localparam logic [3:0] OP_SW    = 4'b0011;
  localparam logic [3:0] OP_BEQ   = 4'b0100;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read port: req/ready request handshake plus an rvalid
// response; the fetch unit is the master, the memory is the slave.
interface instr_fetch_unit_if #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 24
) ();

  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ready;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/instr_fetch_unit_skid.sv
// Two-entry output/skid register pair holding {instr, pc} in front of decode.
// The output entry is what decode sees; the skid catches a word while decode stalls.
module fetch_skid_buffer #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push_i,
  input  logic [INSTR_W-1:0] push_instr_i,
  input  logic [ADDR_W-1:0]  push_pc_i,
  input  logic               pop_i,
  input  logic               flush_i,
  output logic               valid_o,
  output logic               full_o,
  output logic               full_next_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  pc_o
);

  logic               out_vld_q, out_vld_d;
  logic [INSTR_W-1:0] out_instr_q, out_instr_d;
  logic [ADDR_W-1:0]  out_pc_q, out_pc_d;
  logic               skd_vld_q, skd_vld_d;
  logic [INSTR_W-1:0] skd_instr_q, skd_instr_d;
  logic [ADDR_W-1:0]  skd_pc_q, skd_pc_d;
  logic               consume_s;

  assign consume_s = out_vld_q && pop_i;

  // Next-state for both entries; an emptied output entry is zeroed so decode sees 0.
  always_comb begin
    out_vld_d   = out_vld_q;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;
    skd_vld_d   = skd_vld_q;
    skd_instr_d = skd_instr_q;
    skd_pc_d    = skd_pc_q;
    if (flush_i) begin
      out_vld_d   = 1'b0;
      out_instr_d = {INSTR_W{1'b0}};
      out_pc_d    = {ADDR_W{1'b0}};
      skd_vld_d   = 1'b0;
    end else if (!out_vld_q || consume_s) begin
      if (skd_vld_q) begin
        out_vld_d   = 1'b1;
        out_instr_d = skd_instr_q;
        out_pc_d    = skd_pc_q;
        skd_vld_d   = push_i;
        if (push_i) begin
          skd_instr_d = push_instr_i;
          skd_pc_d    = push_pc_i;
        end else begin
          skd_instr_d = skd_instr_q;
          skd_pc_d    = skd_pc_q;
        end
      end else if (push_i) begin
        out_vld_d   = 1'b1;
        out_instr_d = push_instr_i;
        out_pc_d    = push_pc_i;
      end else begin
        out_vld_d   = 1'b0;
        out_instr_d = {INSTR_W{1'b0}};
        out_pc_d    = {ADDR_W{1'b0}};
      end
    end else begin
      if (push_i) begin
        skd_vld_d   = 1'b1;
        skd_instr_d = push_instr_i;
        skd_pc_d    = push_pc_i;
      end else begin
        skd_vld_d   = skd_vld_q;
      end
    end
  end

  // Entry registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_vld_q   <= 1'b0;
      out_instr_q <= {INSTR_W{1'b0}};
      out_pc_q    <= {ADDR_W{1'b0}};
      skd_vld_q   <= 1'b0;
      skd_instr_q <= {INSTR_W{1'b0}};
      skd_pc_q    <= {ADDR_W{1'b0}};
    end else begin
      out_vld_q   <= out_vld_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
      skd_vld_q   <= skd_vld_d;
      skd_instr_q <= skd_instr_d;
      skd_pc_q    <= skd_pc_d;
    end
  end

  assign valid_o     = out_vld_q;
  assign full_o      = skd_vld_q;
  assign full_next_o = skd_vld_d;
  assign instr_o     = out_instr_q;
  assign pc_o        = out_pc_q;

endmodule

// File: rtl/instr_fetch_unit_sva.sv
// Protocol checks for the fetch unit: no response without an outstanding
// request, and no request while the skid entry is occupied.
module instr_fetch_unit_sva (
  input logic                    clk,
  input logic                    rst_n,
  input cpu24_pkg::fetch_state_e state_i,
  input logic                    rvalid_i,
  input logic                    req_i,
  input logic                    skid_full_i
);

  a_stray_rvalid: assert property (@(posedge clk) disable iff (!rst_n)
    !(rvalid_i && (state_i == cpu24_pkg::ST_FETCH)))
    else $error("imem_rvalid with no request outstanding");

  a_req_skid_empty: assert property (@(posedge clk) disable iff (!rst_n)
    req_i |-> !skid_full_i)
    else $error("imem_req raised while skid entry occupied");

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: PC, one-outstanding imem read FSM, branch
// redirect with in-flight flush, and a 2-entry output/skid buffer to decode.
module instr_fetch_unit #(
  parameter int               ADDR_W   = 16,
  parameter int               INSTR_W  = 24,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic                Clock,
  input  logic                Reset_n,
  instr_fetch_unit_if.master  imem,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [ADDR_W-1:0]   branch_target,
  output logic                instr_valid,
  output logic [INSTR_W-1:0]  instr,
  output logic [ADDR_W-1:0]   instr_pc,
  output logic [3:0]          OPCODE
);
  import cpu24_pkg::*;

  fetch_state_e      state_q, state_d;
  fetch_state_e      flush_state_s;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              req_q, req_d;
  logic              accept_s;
  logic              outstanding_s;
  logic              push_s;
  logic              skid_full_s;
  logic              skid_full_next_s;

  assign accept_s = req_q && imem.imem_ready;
  assign push_s   = (state_q == ST_WAIT) && imem.imem_rvalid && !branch_taken;

  // Whether a request is still owed a response after this edge; reset and
  // branch both use this to decide if a stale response must be drained.
  always_comb begin
    case (state_q)
      ST_FETCH: outstanding_s = accept_s;
      ST_WAIT:  outstanding_s = !imem.imem_rvalid;
      ST_DRAIN: outstanding_s = !imem.imem_rvalid;
      default:  outstanding_s = 1'b0;
    endcase
    if (outstanding_s) begin
      flush_state_s = ST_DRAIN;
    end else begin
      flush_state_s = ST_FETCH;
    end
  end

  // FSM and PC next-state; branch overrides everything but reset.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (branch_taken) begin
      state_d = flush_state_s;
      pc_d    = branch_target;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (accept_s) begin
            state_d = ST_WAIT;
            pc_d    = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
          end else begin
            state_d = ST_FETCH;
          end
        end
        ST_WAIT, ST_DRAIN: begin
          if (imem.imem_rvalid) begin
            state_d = ST_FETCH;
          end else begin
            state_d = state_q;
          end
        end
        default: state_d = ST_FETCH;
      endcase
    end
    req_d = (state_d == ST_FETCH) && !skid_full_next_s;
  end

  // State, PC and registered request.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q <= flush_state_s;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;

  // The request PC equals pc_q - 1 once in WAIT, so it is recomputed for the push.
  fetch_skid_buffer #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_skid (
    .clk          (Clock),
    .rst_n        (Reset_n),
    .push_i       (push_s),
    .push_instr_i (imem.imem_rdata),
    .push_pc_i    (pc_q - {{(ADDR_W-1){1'b0}}, 1'b1}),
    .pop_i        (!stall),
    .flush_i      (branch_taken),
    .valid_o      (instr_valid),
    .full_o       (skid_full_s),
    .full_next_o  (skid_full_next_s),
    .instr_o      (instr),
    .pc_o         (instr_pc)
  );

  assign OPCODE = instr[INSTR_W-1 -: OPC_W];

  instr_fetch_unit_sva u_chk (
    .clk         (Clock),
    .rst_n       (Reset_n),
    .state_i     (state_q),
    .rvalid_i    (imem.imem_rvalid),
    .req_i       (req_q),
    .skid_full_i (skid_full_s)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a transaction-level model (PC, one
// outstanding flag, queue of delivered words) is compared every cycle.
module tb_instr_fetch_unit;

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic        stall, branch_taken;
  logic [15:0] branch_target;
  logic        instr_valid;
  logic [23:0] instr;
  logic [15:0] instr_pc;
  logic [3:0]  OPCODE;

  logic        instr_valid2;
  logic [23:0] instr2;
  logic [15:0] instr_pc2;
  logic [3:0]  OPCODE2;
  logic        zero_s = 1'b0;
  logic [15:0] zero16 = 16'h0000;

  instr_fetch_unit_if #(.ADDR_W(16), .INSTR_W(24)) imem ();
  instr_fetch_unit_if #(.ADDR_W(16), .INSTR_W(24)) imem2 ();

  instr_fetch_unit #(.ADDR_W(16), .INSTR_W(24), .RESET_PC(16'h0000)) u_dut (
    .Clock(Clock), .Reset_n(Reset_n), .imem(imem), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .OPCODE(OPCODE)
  );

  instr_fetch_unit #(.ADDR_W(16), .INSTR_W(24), .RESET_PC(16'hFFFF)) u_dut2 (
    .Clock(Clock), .Reset_n(Reset_n), .imem(imem2), .stall(zero_s),
    .branch_taken(zero_s), .branch_target(zero16),
    .instr_valid(instr_valid2), .instr(instr2), .instr_pc(instr_pc2), .OPCODE(OPCODE2)
  );

  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int first_acc = -1;
  int lat = 1;
  bit ready_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- memory for main DUT: latency 'lat', data {8'h60, addr}
  int          mem_cnt = 0;
  logic [15:0] mem_addr;
  initial begin
    imem.imem_ready  = 1'b0;
    imem.imem_rvalid = 1'b0;
    imem.imem_rdata  = 24'h000000;
    forever begin
      @(negedge Clock);
      imem.imem_rvalid = 1'b0;
      if (mem_cnt > 0) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          imem.imem_rvalid = 1'b1;
          imem.imem_rdata  = {8'h60, mem_addr};
        end
      end
      imem.imem_ready = ready_en;
      if (imem.imem_req && ready_en) begin
        mem_cnt  = lat;
        mem_addr = imem.imem_addr;
        if (first_acc < 0 && Reset_n) first_acc = cyc;
      end
    end
  end

  // ---------------- memory for wrap DUT: fixed latency 1
  bit          pend2 = 1'b0;
  logic [15:0] addr2;
  initial begin
    imem2.imem_ready  = 1'b0;
    imem2.imem_rvalid = 1'b0;
    imem2.imem_rdata  = 24'h000000;
    forever begin
      @(negedge Clock);
      imem2.imem_rvalid = pend2;
      if (pend2) imem2.imem_rdata = {8'h60, addr2};
      imem2.imem_ready = ready_en;
      pend2 = imem2.imem_req && ready_en;
      if (pend2) addr2 = imem2.imem_addr;
    end
  end

  // ---------------- behavioural model + per-cycle compare
  logic [39:0] q[$];
  logic [39:0] head;
  logic [15:0] m_pc = 16'h0000;
  logic [15:0] m_raddr = 16'h0000;
  bit          m_out = 1'b0, m_drop = 1'b0, m_rstblk = 1'b0, live = 1'b0;
  bit          exp_req = 1'b0, acc, nout;
  logic [23:0] e_instr;
  logic [15:0] e_pc;

  always @(posedge Clock) begin
    cyc++;
    acc  = exp_req && imem.imem_ready;
    nout = (m_out && !imem.imem_rvalid) || acc;
    if (!Reset_n) begin
      m_out = nout; m_drop = 1'b1; m_pc = 16'h0000;
      q.delete(); m_rstblk = 1'b1; live = 1'b1;
    end else begin
      m_rstblk = 1'b0;
      if (branch_taken) begin
        m_out = nout; m_drop = 1'b1; q.delete(); m_pc = branch_target;
      end else begin
        if (q.size() > 0 && !stall) void'(q.pop_front());
        if (m_out && imem.imem_rvalid) begin
          if (!m_drop) q.push_back({8'h60, m_raddr, m_raddr});
          m_out = 1'b0;
        end
        if (acc) begin
          m_out = 1'b1; m_drop = 1'b0; m_raddr = m_pc; m_pc = m_pc + 16'h0001;
        end
      end
    end
    exp_req = live && !m_rstblk && !m_out && (q.size() < 2);
    if (q.size() > 0) begin
      head = q[0];
      e_instr = head[39:16];
      e_pc = head[15:0];
    end else begin
      e_instr = 24'h000000;
      e_pc = 16'h0000;
    end
    #1;
    if (live) begin
      chk("imem_req", imem.imem_req, exp_req);
      chk("imem_addr", imem.imem_addr, m_pc);
      chk("instr_valid", instr_valid, q.size() > 0);
      chk("instr", instr, e_instr);
      chk("instr_pc", instr_pc, e_pc);
      chk("OPCODE", OPCODE, e_instr[23:20]);
    end
  end

  // ---------------- wrap DUT capture of first two requests / instructions
  bit          d2_arm = 1'b0;
  int          n_a2 = 0, n_v2 = 0;
  logic [15:0] a2 [2];
  logic [15:0] v2 [2];
  always @(posedge Clock) begin
    #1;
    if (d2_arm) begin
      if (imem2.imem_req && n_a2 < 2) begin a2[n_a2] = imem2.imem_addr; n_a2++; end
      if (instr_valid2 && n_v2 < 2) begin v2[n_v2] = instr_pc2; n_v2++; end
    end
  end

  task automatic wait_valid(input int budget, input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (instr_valid) begin ok = 1'b1; break; end
      @(negedge Clock);
    end
    chk(nm, ok, 1'b1);
  endtask

  task automatic wait_out(input bit val, input int budget, input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (m_out == val) begin ok = 1'b1; break; end
      @(negedge Clock);
    end
    chk(nm, ok, 1'b1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"}, imem.imem_req, 1'b0);
    chk({tag, "_addr"}, imem.imem_addr, 16'h0000);
    chk({tag, "_valid"}, instr_valid, 1'b0);
    chk({tag, "_instr"}, instr, 24'h000000);
    chk({tag, "_pc"}, instr_pc, 16'h0000);
    chk({tag, "_opc"}, OPCODE, 4'h0);
  endtask

  initial begin
    Reset_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 16'h0000;
    repeat (2) @(negedge Clock);
    chk_reset_vals("rst0");
    ready_en = 1'b1;
    Reset_n = 1'b1;
    d2_arm = 1'b1;

    // streaming with 1-cycle memory
    wait_valid(20, "first_valid_timeout");
    chk("first_valid_latency", cyc - first_acc, 2);
    chk("first_pc", instr_pc, 16'h0000);
    chk("first_instr", instr, 24'h600000);
    chk("first_opc", OPCODE, 4'h6);
    repeat (8) @(negedge Clock);
    chk("wrap_req0", a2[0], 16'hFFFF);
    chk("wrap_req1", a2[1], 16'h0000);
    chk("wrap_pc0", v2[0], 16'hFFFF);
    chk("wrap_pc1", v2[1], 16'h0000);

    // decode stall for 5 cycles
    wait_valid(10, "stall_valid_timeout");
    stall = 1'b1;
    repeat (5) @(negedge Clock);
    chk("stall_req_low", imem.imem_req, 1'b0);
    chk("stall_valid_held", instr_valid, 1'b1);
    stall = 1'b0;
    repeat (6) @(negedge Clock);

    // branch while a fetch is in flight
    lat = 3;
    wait_out(1'b0, 20, "br_idle_timeout");
    wait_out(1'b1, 20, "br_wait_timeout");
    branch_taken = 1'b1; branch_target = 16'h0040;
    @(negedge Clock);
    branch_taken = 1'b0;
    chk("br_flush_valid", instr_valid, 1'b0);
    wait_valid(40, "br_refetch_timeout");
    chk("br_first_pc", instr_pc, 16'h0040);
    chk("br_first_instr", instr, 24'h600040);

    // branch together with stall while output is valid
    lat = 1;
    repeat (3) @(negedge Clock);
    wait_valid(20, "brst_valid_timeout");
    stall = 1'b1; branch_taken = 1'b1; branch_target = 16'h0100;
    @(negedge Clock);
    stall = 1'b0; branch_taken = 1'b0;
    chk("brst_flush_valid", instr_valid, 1'b0);
    wait_valid(20, "brst_refetch_timeout");
    chk("brst_first_pc", instr_pc, 16'h0100);

    // one-cycle reset while a slow fetch is outstanding
    lat = 4;
    wait_out(1'b0, 20, "rst_idle_timeout");
    wait_out(1'b1, 20, "rst_wait_timeout");
    Reset_n = 1'b0;
    @(negedge Clock);
    Reset_n = 1'b1;
    chk_reset_vals("rst1");
    wait_valid(60, "rst_refetch_timeout");
    chk("rst_first_pc", instr_pc, 16'h0000);
    chk("rst_first_instr", instr, 24'h600000);
    repeat (4) @(negedge Clock);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
